magcompare_seq128: RTL and testbench

- Iterative, MSB-first magnitude comparator for two WIDTH-bit operands (default 128).
- Scans DIGIT bits per cycle from the most significant digit down and produces equal, signed-less-than and unsigned-less-than flags.
- Sequential, area-lean counterpart to the combinational comparator tree, for non-critical compare paths in the datapath.
- Uses a valid/ready handshake on both the operand and the result sides.

---
 rtl/magcompare_seq128_if.sv | 26 ++
 rtl/magcompare_seq128.sv | 135 +++++++++++++
 tb/tb_magcompare_seq128.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/magcompare_seq128_if.sv
// Operand/result handshake bundle for magcompare_seq128.
// The master side supplies the operands and consumes the result. The slave side is the comparator.
interface magcompare_seq128_if #(
  parameter int unsigned WIDTH = 128
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic             OutReady;
  logic             EQ;
  logic             LT;
  logic             LTu;
  logic             Busy;

  modport master (
    output InValid, A, B, OutReady,
    input  InReady, OutValid, EQ, LT, LTu, Busy
  );

  modport slave (
    input  InValid, A, B, OutReady,
    output InReady, OutValid, EQ, LT, LTu, Busy
  );
endinterface

// File: rtl/magcompare_seq128.sv
// Iterative MSB-first magnitude comparator.
// It scans DIGIT bits per cycle from the top digit down and reports EQ, signed LT and unsigned LTu.
// Optional build macro: MAGCMP_EARLY_EXIT_EN. When it is defined, the scan stops at the first
// differing digit. When it is undefined, the scan always runs down to digit 0.
module magcompare_seq128 #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DIGIT = 2
) (
  input logic              clk,
  input logic              reset,
  magcompare_seq128_if.slave bus
);

  localparam int unsigned NumDigits = WIDTH / DIGIT;
  localparam int unsigned IdxW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [IdxW-1:0] TopIdx = IdxW'(NumDigits - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             decided_q, decided_d;
  // Working flags that are recorded at the first differing digit.
  logic             wlt_q, wlt_d, wltu_q, wltu_d;
  // Published result. It holds its value until the next result is written.
  logic             eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;

  logic [DIGIT-1:0] ad, bd, ads, bds;
  logic             diff, ltu_now, lt_now, last;

  // Compare the current digit.
  // The top digit uses a sign-inverted compare so that it gives the two's-complement ordering.
  always_comb begin
    ad           = a_q[idx_q*DIGIT +: DIGIT];
    bd           = b_q[idx_q*DIGIT +: DIGIT];
    ads          = ad;
    bds          = bd;
    ads[DIGIT-1] = ~ad[DIGIT-1];
    bds[DIGIT-1] = ~bd[DIGIT-1];
    diff         = (ad != bd);
    ltu_now      = (ad < bd);
    lt_now       = (idx_q == TopIdx) ? (ads < bds) : ltu_now;
  end

  // Determine when the scan ends.
  always_comb begin
`ifdef MAGCMP_EARLY_EXIT_EN
    last = (idx_q == '0) || (diff && !decided_q);
`else
    last = (idx_q == '0);
`endif
  end

  // Compute the next state, the operand capture and the result recording.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    decided_d = decided_q;
    wlt_d     = wlt_q;
    wltu_d    = wltu_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    ltu_d     = ltu_q;
    unique case (state_q)
      StIdle: begin
        if (bus.InValid) begin
          a_d       = bus.A;
          b_d       = bus.B;
          idx_d     = TopIdx;
          decided_d = 1'b0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (idx_q != '0) idx_d = idx_q - 1'b1;
        if (diff && !decided_q) begin
          decided_d = 1'b1;
          wlt_d     = lt_now;
          wltu_d    = ltu_now;
        end
        if (last) begin
          eq_d    = ~decided_d;
          lt_d    = decided_d & wlt_d;
          ltu_d   = decided_d & wltu_d;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.OutReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Update the state registers. An asynchronous reset aborts any operation in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      wlt_q     <= 1'b0;
      wltu_q    <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      decided_q <= decided_d;
      wlt_q     <= wlt_d;
      wltu_q    <= wltu_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      ltu_q     <= ltu_d;
    end
  end

  // Drive the outputs. They are decoded directly from the state and result registers.
  always_comb begin
    bus.InReady  = (state_q == StIdle);
    bus.Busy     = (state_q == StScan);
    bus.OutValid = (state_q == StDone);
    bus.EQ       = eq_q;
    bus.LT       = lt_q;
    bus.LTu      = ltu_q;
  end

endmodule

// File: tb/tb_magcompare_seq128.sv
// Self-checking bench for magcompare_seq128.
// It covers directed cases plus random pairs, checked against an arithmetic reference model.
module tb_magcompare_seq128;
  localparam int W = 128;
  localparam int D = 2;
  localparam int N = W / D;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  magcompare_seq128_if #(.WIDTH(W)) bus ();

  magcompare_seq128 #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference latency: WIDTH/DIGIT edges, or k+1 edges with early exit (k = equal leading digits).
  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    logic [W-1:0] ta, tb;
    lat = N;
`ifdef MAGCMP_EARLY_EXIT_EN
    for (int i = N - 1; i >= 0; i--) begin
      ta = a >> (i * D);
      tb = b >> (i * D);
      if (ta[D-1:0] != tb[D-1:0]) begin
        lat = N - i;
        break;
      end
    end
`endif
    return lat;
  endfunction

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    chk({tag, " InReady before accept"}, 32'(bus.InReady), 32'd1);
    bus.A       = a;
    bus.B       = b;
    bus.InValid = 1'b1;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.OutValid) break;
    end
  endtask

  task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input int cnt,
                              input string tag);
    chk({tag, " latency"}, 32'(cnt), 32'(exp_lat(a, b)));
    chk({tag, " OutValid"}, 32'(bus.OutValid), 32'd1);
    chk({tag, " EQ"}, 32'(bus.EQ), 32'(a == b));
    chk({tag, " LT"}, 32'(bus.LT), 32'($signed(a) < $signed(b)));
    chk({tag, " LTu"}, 32'(bus.LTu), 32'(a < b));
    chk({tag, " Busy in DONE"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic consume(input string tag);
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1;
    bus.OutReady = 1'b0;
    chk({tag, " OutValid after consume"}, 32'(bus.OutValid), 32'd0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int cnt;
    start(a, b, tag);
    wait_done(cnt);
    check_result(a, b, cnt, tag);
    consume(tag);
  endtask

  initial begin
    logic [W-1:0] pa, pb, ra, rb, r1;
    logic         s_eq, s_lt, s_ltu;
    int           cnt;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    pa = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // Reset state
    #12;
    chk("reset InReady", 32'(bus.InReady), 32'd1);
    chk("reset OutValid", 32'(bus.OutValid), 32'd0);
    chk("reset flags", {29'd0, bus.EQ, bus.LT, bus.LTu}, 32'd0);
    chk("reset Busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run(pa, pa, "t1 equal");
    run(128'd1, 128'd2, "t2 digit0");
    run({1'b1, 127'd0}, 128'd0, "t3 sign");
    run({1'b0, {127{1'b1}}}, {128{1'b1}}, "t4 maxpos");

    // Hold the result while new operands are offered, then check that re-accept is delayed
    start(128'd1, 128'd2, "t5");
    wait_done(cnt);
    check_result(128'd1, 128'd2, cnt, "t5");
    s_eq  = bus.EQ;
    s_lt  = bus.LT;
    s_ltu = bus.LTu;
    pb = 128'd5;
    bus.A       = pb;
    bus.B       = 128'd9;
    bus.InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t5 hold OutValid", 32'(bus.OutValid), 32'd1);
      chk("t5 hold InReady", 32'(bus.InReady), 32'd0);
      chk("t5 hold flags", {29'd0, bus.EQ, bus.LT, bus.LTu}, {29'd0, s_eq, s_lt, s_ltu});
    end
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1;
    bus.OutReady = 1'b0;
    chk("t5 no same-cycle accept Busy", 32'(bus.Busy), 32'd0);
    chk("t5 InReady after consume", 32'(bus.InReady), 32'd1);
    chk("t5 flags kept after consume", {29'd0, bus.EQ, bus.LT, bus.LTu},
        {29'd0, s_eq, s_lt, s_ltu});
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    chk("t5 accepted next cycle", 32'(bus.Busy), 32'(exp_lat(pb, 128'd9) != 1 || 1'b1));
    wait_done(cnt);
    check_result(pb, 128'd9, cnt, "t5 second");
    consume("t5 second");

    // Reset in the middle of a scan
    start(pa, pa, "t6");
    repeat (10) @(posedge clk);
    #1;
    chk("t6 Busy before reset", 32'(bus.Busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6 reset InReady", 32'(bus.InReady), 32'd1);
    chk("t6 reset outputs", {28'd0, bus.OutValid, bus.EQ, bus.LT, bus.LTu}, 32'd0);
    chk("t6 reset Busy", 32'(bus.Busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(128'd5, 128'd3, "t6 after reset");

    // Random pairs, with some sharing a random-length common prefix
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (i % 3 == 1) begin
        r1 = {128{1'b1}} >> $urandom_range(0, W - 1);
        rb = (ra & ~r1) | (rb & r1);
      end else if (i % 6 == 2) begin
        rb = ra;
      end
      run(ra, rb, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
